// File: rtl/lvds_out_pattern_tx.sv
// lvds_out_pattern_tx
// Drives a test square wave onto the four LVDS control outputs, alternating
// between channel group 0 (im_upr_cont_out / izp_upr_cont_out) and group 1
// (di_1_out / izp_1_out), with an idle gap between groups. The active group
// and group boundaries are published so the input checker samples the
// matching pair.
//
// Optional build macro: LVDS_TX_PRBS_EN
//   defined   - di_1_out carries bit 0 of a PRBS7 (x^7+x^6+1) during group 1
//   undefined - di_1_out carries the test clock like every other line
//
// Structure: a sequencer stage (_p0) holding state, prescaler, test clock and
// counters, followed by a registered output stage, so every output is one
// clock behind the sequencer.
module lvds_out_pattern_tx #(
    parameter int HALF_PERIOD       = 50,
    parameter int PERIODS_PER_GROUP = 8,
    parameter int GAP_PERIODS       = 2
) (
    input  logic        clk_100Mz,
    input  logic        rst,
    input  logic        enable,
    output logic        im_upr_cont_out,
    output logic        izp_upr_cont_out,
    output logic        di_1_out,
    output logic        izp_1_out,
    output logic        choose_channel,
    output logic        group_valid,
    output logic        group_done,
    output logic [15:0] cycle_count
);

    localparam int GAP_LEN = GAP_PERIODS * 2 * HALF_PERIOD;
    localparam int PRESC_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int PER_W   = $clog2(PERIODS_PER_GROUP + 1);
    localparam int GAP_W   = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(HALF_PERIOD - 1);
    localparam logic [PER_W-1:0]   PER_LAST   = PER_W'(PERIODS_PER_GROUP);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Sequencer stage
    state_t             state_p0,   state_nxt;
    logic [PRESC_W-1:0] presc_p0,   presc_nxt;
    logic               tclk_p0,    tclk_nxt;
    logic [PER_W-1:0]   per_cnt_p0, per_cnt_nxt;
    logic [GAP_W-1:0]   gap_cnt_p0, gap_cnt_nxt;
    logic               chan_p0,    chan_nxt;

    logic presc_end;
    logic gap_first;
    logic grp1_line_a;

    assign presc_end = (presc_p0 == PRESC_LAST);
    assign gap_first = (state_p0 == GAP) && (gap_cnt_p0 == '0);

    // Sequencer registers; reset always returns to IDLE with group 0 next
    always_ff @(posedge clk_100Mz) begin
        if (rst) begin
            state_p0   <= IDLE;
            presc_p0   <= '0;
            tclk_p0    <= 1'b0;
            per_cnt_p0 <= '0;
            gap_cnt_p0 <= '0;
            chan_p0    <= 1'b0;
        end else begin
            state_p0   <= state_nxt;
            presc_p0   <= presc_nxt;
            tclk_p0    <= tclk_nxt;
            per_cnt_p0 <= per_cnt_nxt;
            gap_cnt_p0 <= gap_cnt_nxt;
            chan_p0    <= chan_nxt;
        end
    end

    // Next-state logic: prescaler, test clock, period and gap counting
    always_comb begin
        state_nxt   = state_p0;
        presc_nxt   = presc_p0;
        tclk_nxt    = tclk_p0;
        per_cnt_nxt = per_cnt_p0;
        gap_cnt_nxt = gap_cnt_p0;
        chan_nxt    = chan_p0;

        case (state_p0)
            IDLE: begin
                presc_nxt   = '0;
                per_cnt_nxt = '0;
                gap_cnt_nxt = '0;
                tclk_nxt    = 1'b0;
                if (enable) begin
                    state_nxt = DRIVE;
                    tclk_nxt  = 1'b1;
                end
            end

            DRIVE: begin
                if (presc_end) begin
                    presc_nxt = '0;
                    if (tclk_p0) begin
                        // Falling transition closes one more period
                        tclk_nxt    = 1'b0;
                        per_cnt_nxt = per_cnt_p0 + 1'b1;
                    end else if (per_cnt_p0 == PER_LAST) begin
                        // Low phase of the last period is over: leave for the
                        // gap instead of starting another high phase
                        state_nxt   = GAP;
                        per_cnt_nxt = '0;
                        gap_cnt_nxt = '0;
                    end else begin
                        tclk_nxt = 1'b1;
                    end
                end else begin
                    presc_nxt = presc_p0 + 1'b1;
                end
            end

            GAP: begin
                presc_nxt = '0;
                tclk_nxt  = 1'b0;
                if (gap_cnt_p0 == GAP_LAST) begin
                    // enable is only looked at here; a drop during DRIVE lets
                    // the group and its gap run to completion
                    gap_cnt_nxt = '0;
                    chan_nxt    = ~chan_p0;
                    if (enable) begin
                        state_nxt = DRIVE;
                        tclk_nxt  = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    gap_cnt_nxt = gap_cnt_p0 + 1'b1;
                end
            end

            default: begin
                state_nxt   = IDLE;
                presc_nxt   = '0;
                tclk_nxt    = 1'b0;
                per_cnt_nxt = '0;
                gap_cnt_nxt = '0;
            end
        endcase
    end

`ifdef LVDS_TX_PRBS_EN
    logic [6:0] prbs_p0;
    logic       prbs_step;

    // Advance on every rising test-clock transition of a group-1 DRIVE,
    // including the transition that enters DRIVE
    assign prbs_step = tclk_nxt && !tclk_p0 && (state_nxt == DRIVE) && chan_nxt;

    // PRBS7 x^7+x^6+1, shifting left with feedback into bit 0; seeded only by rst
    always_ff @(posedge clk_100Mz) begin
        if (rst) begin
            prbs_p0 <= 7'h7F;
        end else if (prbs_step) begin
            prbs_p0 <= {prbs_p0[5:0], prbs_p0[6] ^ prbs_p0[5]};
        end
    end

    assign grp1_line_a = prbs_p0[0];
`else
    assign grp1_line_a = tclk_p0;
`endif

    // Output stage: register every output from the sequencer state
    always_ff @(posedge clk_100Mz) begin
        if (rst) begin
            im_upr_cont_out  <= 1'b0;
            izp_upr_cont_out <= 1'b0;
            di_1_out         <= 1'b0;
            izp_1_out        <= 1'b0;
            choose_channel   <= 1'b0;
            group_valid      <= 1'b0;
            group_done       <= 1'b0;
            cycle_count      <= 16'd0;
        end else begin
            im_upr_cont_out  <= (state_p0 == DRIVE) && !chan_p0 && tclk_p0;
            izp_upr_cont_out <= (state_p0 == DRIVE) && !chan_p0 && tclk_p0;
            di_1_out         <= (state_p0 == DRIVE) &&  chan_p0 && grp1_line_a;
            izp_1_out        <= (state_p0 == DRIVE) &&  chan_p0 && tclk_p0;
            choose_channel   <= chan_p0;
            group_valid      <= (state_p0 == DRIVE);
            group_done       <= gap_first;
            // A full cycle is counted when group 1 finishes; wraps naturally
            if (gap_first && chan_p0) begin
                cycle_count <= cycle_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_lvds_out_pattern_tx.sv
// Self-checking bench for lvds_out_pattern_tx at default parameters.
// Time index t counts cycles after edge N, the first rising edge at which
// enable is sampled high; outputs are sampled on the falling edge.
module tb_lvds_out_pattern_tx;

    logic        clk_100Mz = 1'b0;
    logic        rst;
    logic        enable;
    logic        im_upr_cont_out;
    logic        izp_upr_cont_out;
    logic        di_1_out;
    logic        izp_1_out;
    logic        choose_channel;
    logic        group_valid;
    logic        group_done;
    logic [15:0] cycle_count;

    always #5 clk_100Mz = ~clk_100Mz;

    lvds_out_pattern_tx dut (
        .clk_100Mz        (clk_100Mz),
        .rst              (rst),
        .enable           (enable),
        .im_upr_cont_out  (im_upr_cont_out),
        .izp_upr_cont_out (izp_upr_cont_out),
        .di_1_out         (di_1_out),
        .izp_1_out        (izp_1_out),
        .choose_channel   (choose_channel),
        .group_valid      (group_valid),
        .group_done       (group_done),
        .cycle_count      (cycle_count)
    );

`ifdef LVDS_TX_PRBS_EN
    localparam logic [3:0] LMASK = 4'b1101;
`else
    localparam logic [3:0] LMASK = 4'b1111;
`endif

    typedef struct {
        int          at;
        logic        en;
        logic [3:0]  lines;   // {im_upr, izp_upr, di_1, izp_1}
        logic        valid;
        logic        done;
        logic        chan;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   t;

    function automatic vec_t mk(int at, logic [3:0] l, logic v, logic d, logic c, logic [15:0] n);
        vec_t r;
        r.at = at; r.en = 1'b1; r.lines = l; r.valid = v; r.done = d; r.chan = c; r.cnt = n;
        return r;
    endfunction

    task automatic step();
        @(posedge clk_100Mz);
        @(negedge clk_100Mz);
        t++;
    endtask

    task automatic step_to(input int k);
        while (t < k) step();
    endtask

    task automatic chk(input string name, input logic [3:0] el, input logic ev,
                       input logic ed, input logic ec, input logic [15:0] en);
        logic [3:0] gl;
        gl = {im_upr_cont_out, izp_upr_cont_out, di_1_out, izp_1_out} & LMASK;
        n_vec++;
        if (gl !== (el & LMASK) || group_valid !== ev || group_done !== ed ||
            choose_channel !== ec || cycle_count !== en) begin
            n_bad++;
            $display("FAIL %s t=%0d: got lines=%b vld=%b done=%b chan=%b cnt=%0d, want lines=%b vld=%b done=%b chan=%b cnt=%0d",
                     name, t, gl, group_valid, group_done, choose_channel, cycle_count,
                     el & LMASK, ev, ed, ec, en);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Hold rst for 5 cycles with enable high, then release with enable=en_after.
    task automatic do_reset(input logic en_after);
        @(negedge clk_100Mz);
        rst    = 1'b1;
        enable = 1'b1;
        t      = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("reset_hold", 4'b0000, 1'b0, 1'b0, 1'b0, 16'd0);
        end
        rst    = 1'b0;
        enable = en_after;
        t      = -1;
    endtask

    initial begin
        int highs;
        int falls;
        logic prev_im;
        logic side_bad;

        rst    = 1'b1;
        enable = 1'b0;

        // Alternation run: expected checkpoints for groups 0,1,0,1
        tbl.push_back(mk(   0, 4'b0000, 1'b0, 1'b0, 1'b0, 16'd0));
        tbl.push_back(mk(   1, 4'b1100, 1'b1, 1'b0, 1'b0, 16'd0));
        tbl.push_back(mk(  50, 4'b1100, 1'b1, 1'b0, 1'b0, 16'd0));
        tbl.push_back(mk(  51, 4'b0000, 1'b1, 1'b0, 1'b0, 16'd0));
        tbl.push_back(mk( 100, 4'b0000, 1'b1, 1'b0, 1'b0, 16'd0));
        tbl.push_back(mk( 101, 4'b1100, 1'b1, 1'b0, 1'b0, 16'd0));
        tbl.push_back(mk( 750, 4'b1100, 1'b1, 1'b0, 1'b0, 16'd0));
        tbl.push_back(mk( 751, 4'b0000, 1'b1, 1'b0, 1'b0, 16'd0));
        tbl.push_back(mk( 800, 4'b0000, 1'b1, 1'b0, 1'b0, 16'd0));
        tbl.push_back(mk( 801, 4'b0000, 1'b0, 1'b1, 1'b0, 16'd0));
        tbl.push_back(mk( 802, 4'b0000, 1'b0, 1'b0, 1'b0, 16'd0));
        tbl.push_back(mk(1000, 4'b0000, 1'b0, 1'b0, 1'b0, 16'd0));
        tbl.push_back(mk(1001, 4'b0011, 1'b1, 1'b0, 1'b1, 16'd0));
        tbl.push_back(mk(1050, 4'b0011, 1'b1, 1'b0, 1'b1, 16'd0));
        tbl.push_back(mk(1051, 4'b0000, 1'b1, 1'b0, 1'b1, 16'd0));
        tbl.push_back(mk(1800, 4'b0000, 1'b1, 1'b0, 1'b1, 16'd0));
        tbl.push_back(mk(1801, 4'b0000, 1'b0, 1'b1, 1'b1, 16'd1));
        tbl.push_back(mk(2000, 4'b0000, 1'b0, 1'b0, 1'b1, 16'd1));
        tbl.push_back(mk(2001, 4'b1100, 1'b1, 1'b0, 1'b0, 16'd1));
        tbl.push_back(mk(2801, 4'b0000, 1'b0, 1'b1, 1'b0, 16'd1));
        tbl.push_back(mk(3000, 4'b0000, 1'b0, 1'b0, 1'b0, 16'd1));
        tbl.push_back(mk(3001, 4'b0011, 1'b1, 1'b0, 1'b1, 16'd1));
        tbl.push_back(mk(3800, 4'b0000, 1'b1, 1'b0, 1'b1, 16'd1));
        tbl.push_back(mk(3801, 4'b0000, 1'b0, 1'b1, 1'b1, 16'd2));
        tbl.push_back(mk(3802, 4'b0000, 1'b0, 1'b0, 1'b1, 16'd2));

        // Reset, then alternation with enable held high
        do_reset(1'b1);
        foreach (tbl[i]) begin
            enable = tbl[i].en;
            step_to(tbl[i].at);
            chk($sformatf("alt@%0d", tbl[i].at), tbl[i].lines, tbl[i].valid,
                tbl[i].done, tbl[i].chan, tbl[i].cnt);
        end

        // Early drop: enable falls 300 cycles into group 0
        do_reset(1'b1);
        highs    = 0;
        falls    = 0;
        prev_im  = 1'b0;
        side_bad = 1'b0;
        while (t < 1100) begin
            step();
            if (t == 300) enable = 1'b0;
            if (im_upr_cont_out) highs++;
            if (prev_im && !im_upr_cont_out) falls++;
            if (di_1_out || izp_1_out) side_bad = 1'b1;
            prev_im = im_upr_cont_out;
            if (t == 801)  chk("drop_done",   4'b0000, 1'b0, 1'b1, 1'b0, 16'd0);
            if (t == 1001) chk("drop_idle",   4'b0000, 1'b0, 1'b0, 1'b1, 16'd0);
            if (t == 1100) chk("drop_idle2",  4'b0000, 1'b0, 1'b0, 1'b1, 16'd0);
        end
        chk_int("drop_high_cycles", highs, 400);
        chk_int("drop_periods", falls, 8);
        chk_int("drop_group1_quiet", int'(side_bad), 0);

        // Reset in the middle of a group-1 DRIVE
        do_reset(1'b1);
        step_to(1150);
        chk("mid_g1_before", 4'b0011, 1'b1, 1'b0, 1'b1, 16'd0);
        rst = 1'b1;
        step();
        chk("mid_g1_reset", 4'b0000, 1'b0, 1'b0, 1'b0, 16'd0);
        rst = 1'b0;
        t   = -1;
        step_to(0);
        chk("mid_g1_rel0", 4'b0000, 1'b0, 1'b0, 1'b0, 16'd0);
        step_to(1);
        chk("mid_g1_g0first", 4'b1100, 1'b1, 1'b0, 1'b0, 16'd0);

`ifdef LVDS_TX_PRBS_EN
        // PRBS on di_1_out in the first group 1 after reset
        do_reset(1'b1);
        for (int j = 0; j < 7; j++) begin
            step_to(1001 + 100 * j);
            chk_int($sformatf("prbs_bit%0d", j), int'(di_1_out), (j == 6) ? 1 : 0);
            chk_int($sformatf("prbs_izp1_%0d", j), int'(izp_1_out), 1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
